// File: rtl/ab_seq_driver_pkg.sv
// Shared definitions for the a/b sequence driver: FSM state encodings and
// a small decode helper used by the top level.
package ab_seq_driver_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_DRIVE = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // The unused encoding 2'b11 is neither busy nor done; the FSM recovers to IDLE.
    function automatic logic state_is_busy(input logic [1:0] s);
        return (s == ST_DRIVE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/ab_seq_driver_shift_reg_piso.sv
// Parallel-load, shift-right register with serial output at bit 0.
// Zeros shift in from the top, so the register empties after LEN shifts.
module shift_reg_piso #(
    parameter int LEN = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic           shift_i,
    input  logic           clear_i,
    input  logic [LEN-1:0] par_i,
    output logic           ser_o
);

    logic [LEN-1:0] sr_q;

    // Clear has priority so the final shift of a run leaves the output low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else if (clear_i) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= par_i;
        end else if (shift_i) begin
            sr_q <= {1'b0, sr_q[LEN-1:1]};
        end
    end

    assign ser_o = sr_q[0];

endmodule

// File: rtl/ab_seq_driver.sv
// Serialises pat_a/pat_b onto a/b LSB first, samples o_in on every driven
// cycle into resp, and pulses done for one cycle when the run completes.
module ab_seq_driver
    import ab_seq_driver_pkg::*;
#(
    parameter int LEN   = 8,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [LEN-1:0] pat_a,
    input  logic [LEN-1:0] pat_b,
    input  logic           o_in,
    output logic           a,
    output logic           b,
    output logic           busy,
    output logic           done,
    output logic [LEN-1:0] resp,
    output logic [1:0]     state_dbg
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(LEN - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN-1:0]   resp_q, resp_d;
    logic             load, shift, clear;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        load    = 1'b0;
        shift   = 1'b0;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    resp_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // o_in here is the response to the bit currently on a/b.
                resp_d = {o_in, resp_q[LEN-1:1]};
                shift  = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    clear   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    shift_reg_piso #(.LEN(LEN)) u_sr_a (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (shift),
        .clear_i (clear),
        .par_i   (pat_a),
        .ser_o   (a)
    );

    shift_reg_piso #(.LEN(LEN)) u_sr_b (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (shift),
        .clear_i (clear),
        .par_i   (pat_b),
        .ser_o   (b)
    );

    assign busy      = state_is_busy(state_q);
    assign done      = (state_q == ST_DONE);
    assign resp      = resp_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ab_seq_driver.sv
// Bench for ab_seq_driver: loopback o_in=a&b on an 8-bit instance and
// o_in=a on a 4-bit instance; expected responses flow through a queue.
module tb_ab_seq_driver;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] pat_a, pat_b;
    logic       o_in;
    logic       a, b, busy, done;
    logic [7:0] resp;
    logic [1:0] state_dbg;

    logic       start4;
    logic [3:0] pat_a4, pat_b4;
    logic       o_in4;
    logic       a4, b4, busy4, done4;
    logic [3:0] resp4;
    logic [1:0] state_dbg4;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] pa;
        logic [7:0] pb;
        logic [7:0] exp_resp;
    } vec_t;

    vec_t vecs[5];

    ab_seq_driver #(.LEN(8), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pat_a     (pat_a),
        .pat_b     (pat_b),
        .o_in      (o_in),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .resp      (resp),
        .state_dbg (state_dbg)
    );

    ab_seq_driver #(.LEN(4), .CNT_W(3)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .start     (start4),
        .pat_a     (pat_a4),
        .pat_b     (pat_b4),
        .o_in      (o_in4),
        .a         (a4),
        .b         (b4),
        .busy      (busy4),
        .done      (done4),
        .resp      (resp4),
        .state_dbg (state_dbg4)
    );

    assign o_in  = a & b;
    assign o_in4 = a4;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic pop_and_check(input string name, input logic [7:0] act);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(name, {24'd0, act}, {24'd0, e});
        end
    endtask

    // Full run on the 8-bit instance: per-cycle bit/busy/done checks, then resp.
    task automatic run8(input logic [7:0] pa, input logic [7:0] pb, input logic [7:0] exp_r);
        @(negedge clk);
        pat_a = pa;
        pat_b = pb;
        start = 1'b1;
        exp_q.push_back(exp_r);
        @(negedge clk);
        start = 1'b0;
        pat_a = $urandom_range(0, 255);
        pat_b = $urandom_range(0, 255);
        for (int i = 0; i < 8; i++) begin
            check("run_a", {31'd0, a}, {31'd0, pa[i]});
            check("run_b", {31'd0, b}, {31'd0, pb[i]});
            check("run_busy", {31'd0, busy}, 32'd1);
            check("run_done_early", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        check("run_done", {31'd0, done}, 32'd1);
        check("run_done_ab", {30'd0, a, b}, 32'd0);
        pop_and_check("run_resp", resp);
        @(negedge clk);
        check("run_idle_busy", {31'd0, busy}, 32'd0);
        check("run_idle_done", {31'd0, done}, 32'd0);
        check("run_resp_held", {24'd0, resp}, {24'd0, exp_r});
    endtask

    initial begin
        logic [7:0] ra, rb;

        vecs[0] = '{pa: 8'hF0, pb: 8'hAA, exp_resp: 8'hA0};
        vecs[1] = '{pa: 8'hFF, pb: 8'h0F, exp_resp: 8'h0F};
        vecs[2] = '{pa: 8'h5A, pb: 8'h3C, exp_resp: 8'h18};
        vecs[3] = '{pa: 8'h81, pb: 8'hFF, exp_resp: 8'h81};
        vecs[4] = '{pa: 8'h00, pb: 8'hFF, exp_resp: 8'h00};

        reset  = 1'b1;
        start  = 1'b0;
        pat_a  = 8'h00;
        pat_b  = 8'h00;
        start4 = 1'b0;
        pat_a4 = 4'h0;
        pat_b4 = 4'h0;

        // Reset state and quiescence without start
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_a", {31'd0, a}, 32'd0);
        check("rst_b", {31'd0, b}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_resp", {24'd0, resp}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        pat_a = 8'hFF;
        pat_b = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_start", {30'd0, busy, a}, 32'd0);
        end

        // Table-driven runs
        for (int v = 0; v < 5; v++) begin
            run8(vecs[v].pa, vecs[v].pb, vecs[v].exp_resp);
        end

        // Random runs with a bit-level model of the loopback
        for (int r = 0; r < 4; r++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            run8(ra, rb, ra & rb);
        end

        // Start pulses during DRIVE and DONE are ignored; pattern changes ignored
        @(negedge clk);
        pat_a = 8'hF0;
        pat_b = 8'hAA;
        start = 1'b1;
        exp_q.push_back(8'hA0);
        @(negedge clk);
        start = 1'b0;
        pat_a = 8'h00;
        pat_b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check("ign_a", {31'd0, a}, {31'd0, 1'(8'hF0 >> i)});
            check("ign_busy", {31'd0, busy}, 32'd1);
            start = (i == 3);
            @(negedge clk);
        end
        start = 1'b0;
        check("ign_done", {31'd0, done}, 32'd1);
        pop_and_check("ign_resp", resp);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("ign_not_queued", {31'd0, busy}, 32'd0);
        check("ign_resp_held", {24'd0, resp}, 32'hA0);
        run8(8'h3C, 8'hFF, 8'h3C);

        // Asynchronous reset mid-run during bit 3
        @(negedge clk);
        pat_a = 8'hFF;
        pat_b = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pre_a", {31'd0, a}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_a", {31'd0, a}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_resp", {24'd0, resp}, 32'd0);
        check("abort_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("abort_no_done", {30'd0, done, busy}, 32'd0);
        end

        // start held high: back-to-back runs with period LEN+2
        @(negedge clk);
        pat_a = 8'h01;
        pat_b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        for (int run = 0; run < 3; run++) begin
            exp_q.push_back(8'h01);
            for (int c = 0; c < 8; c++) begin
                check("b2b_a", {31'd0, a}, (c == 0) ? 32'd1 : 32'd0);
                check("b2b_busy", {31'd0, busy}, 32'd1);
                @(negedge clk);
            end
            check("b2b_done", {31'd0, done}, 32'd1);
            pop_and_check("b2b_resp", resp);
            @(negedge clk);
            check("b2b_idle", {30'd0, busy, done}, 32'd0);
            if (run == 2) start = 1'b0;
            @(negedge clk);
        end
        check("b2b_stopped", {31'd0, busy}, 32'd0);

        // LEN=4 instance with o_in = a
        @(negedge clk);
        pat_a4 = 4'b1010;
        pat_b4 = 4'b1111;
        start4 = 1'b1;
        exp_q.push_back(8'h0A);
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("len4_a", {31'd0, a4}, {31'd0, 1'(4'b1010 >> i)});
            check("len4_b", {31'd0, b4}, 32'd1);
            check("len4_done_early", {31'd0, done4}, 32'd0);
            @(negedge clk);
        end
        check("len4_done", {31'd0, done4}, 32'd1);
        check("len4_busy", {31'd0, busy4}, 32'd1);
        pop_and_check("len4_resp", {4'd0, resp4});
        @(negedge clk);
        check("len4_idle", {30'd0, busy4, done4}, 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
